// File: rtl/alu_exec_ctrl.sv
// alu_exec_ctrl: single-issue execute controller wrapped around the 16-bit alu.
// Takes one instruction per handshake, reads two operands from an 8xN register
// file, pulses alu enable once, then writes back the result and latches flags.
module alu_exec_ctrl #(
    parameter int N = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         instr_valid,
    input  logic [15:0]  instr,
    output logic         instr_ready,
    input  logic         ld_en,
    input  logic [2:0]   ld_addr,
    input  logic [N-1:0] ld_data,
    output logic [2:0]   alu_control,
    output logic [N-1:0] alu_a,
    output logic [N-1:0] alu_b,
    output logic         alu_enable,
    input  logic [N-1:0] alu_result,
    input  logic         alu_overflow,
    input  logic         alu_zero,
    input  logic         alu_negative,
    output logic         flag_v,
    output logic         flag_z,
    output logic         flag_n,
    output logic         wb_valid,
    output logic [2:0]   wb_addr,
    output logic [N-1:0] wb_data,
    input  logic [2:0]   dbg_addr,
    output logic [N-1:0] dbg_data
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_READ = 2'd1,
        S_EXEC = 2'd2,
        S_WB   = 2'd3
    } state_t;

    state_t         state_q, state_d;
    // Latched instruction fields: [11:9] op, [8:6] rd, [5:3] ra, [2:0] rb
    logic [11:0]    instr_q, instr_d;
    logic [N-1:0]   regs_q [0:7];
    logic [N-1:0]   regs_d [0:7];
    logic [N-1:0]   alu_a_q, alu_a_d;
    logic [N-1:0]   alu_b_q, alu_b_d;
    logic [2:0]     alu_control_q, alu_control_d;
    logic           alu_enable_q, alu_enable_d;
    logic           flag_v_q, flag_v_d;
    logic           flag_z_q, flag_z_d;
    logic           flag_n_q, flag_n_d;
    logic           wb_valid_q, wb_valid_d;
    logic [2:0]     wb_addr_q, wb_addr_d;
    logic [N-1:0]   wb_data_q, wb_data_d;

    logic [2:0]     op_f, rd_f, ra_f, rb_f;
    logic           instr_unused;

    // Low nibble of the instruction word carries no meaning.
    assign instr_unused = ^instr[3:0];

    assign op_f = instr_q[11:9];
    assign rd_f = instr_q[8:6];
    assign ra_f = instr_q[5:3];
    assign rb_f = instr_q[2:0];

    // r0 is hardwired to zero on every read port.
    function automatic logic [N-1:0] reg_read(input logic [2:0] addr);
        return (addr == 3'd0) ? '0 : regs_q[addr];
    endfunction

    assign instr_ready = (state_q == S_IDLE);
    assign alu_control = alu_control_q;
    assign alu_a       = alu_a_q;
    assign alu_b       = alu_b_q;
    assign alu_enable  = alu_enable_q;
    assign flag_v      = flag_v_q;
    assign flag_z      = flag_z_q;
    assign flag_n      = flag_n_q;
    assign wb_valid    = wb_valid_q;
    assign wb_addr     = wb_addr_q;
    assign wb_data     = wb_data_q;
    assign dbg_data    = reg_read(dbg_addr);

    // Next-state and datapath update for the IDLE/READ/EXEC/WB sequence.
    always_comb begin
        state_d       = state_q;
        instr_d       = instr_q;
        regs_d        = regs_q;
        alu_a_d       = alu_a_q;
        alu_b_d       = alu_b_q;
        alu_control_d = alu_control_q;
        alu_enable_d  = alu_enable_q;
        flag_v_d      = flag_v_q;
        flag_z_d      = flag_z_q;
        flag_n_d      = flag_n_q;
        wb_valid_d    = 1'b0;
        wb_addr_d     = wb_addr_q;
        wb_data_d     = wb_data_q;

        unique case (state_q)
            S_IDLE: begin
                // Preload and accept may coincide; READ then sees the new value.
                if (ld_en && (ld_addr != 3'd0)) begin
                    regs_d[ld_addr] = ld_data;
                end
                if (instr_valid) begin
                    instr_d = instr[15:4];
                    state_d = S_READ;
                end
            end
            S_READ: begin
                alu_a_d       = reg_read(ra_f);
                alu_b_d       = reg_read(rb_f);
                alu_control_d = op_f;
                state_d       = S_EXEC;
            end
            S_EXEC: begin
                alu_enable_d = 1'b1;
                state_d      = S_WB;
            end
            S_WB: begin
                if (rd_f != 3'd0) begin
                    regs_d[rd_f] = alu_result;
                end
                flag_v_d     = alu_overflow;
                flag_z_d     = alu_zero;
                flag_n_d     = alu_negative;
                wb_valid_d   = 1'b1;
                wb_addr_d    = rd_f;
                wb_data_d    = alu_result;
                alu_enable_d = 1'b0;
                state_d      = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State register; reset clears every architectural register and output.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= S_IDLE;
            instr_q       <= '0;
            for (int i = 0; i < 8; i++) begin
                regs_q[i] <= '0;
            end
            alu_a_q       <= '0;
            alu_b_q       <= '0;
            alu_control_q <= '0;
            alu_enable_q  <= 1'b0;
            flag_v_q      <= 1'b0;
            flag_z_q      <= 1'b0;
            flag_n_q      <= 1'b0;
            wb_valid_q    <= 1'b0;
            wb_addr_q     <= '0;
            wb_data_q     <= '0;
        end else begin
            state_q       <= state_d;
            instr_q       <= instr_d;
            regs_q        <= regs_d;
            alu_a_q       <= alu_a_d;
            alu_b_q       <= alu_b_d;
            alu_control_q <= alu_control_d;
            alu_enable_q  <= alu_enable_d;
            flag_v_q      <= flag_v_d;
            flag_z_q      <= flag_z_d;
            flag_n_q      <= flag_n_d;
            wb_valid_q    <= wb_valid_d;
            wb_addr_q     <= wb_addr_d;
            wb_data_q     <= wb_data_d;
        end
    end

endmodule

// File: tb/tb_alu_exec_ctrl.sv
// Directed bench for alu_exec_ctrl with a behavioural alu attached.
module tb_alu_exec_ctrl;

    localparam int N = 16;

    logic         clk = 1'b0;
    logic         rst;
    logic         instr_valid;
    logic [15:0]  instr;
    logic         instr_ready;
    logic         ld_en;
    logic [2:0]   ld_addr;
    logic [N-1:0] ld_data;
    logic [2:0]   alu_control;
    logic [N-1:0] alu_a, alu_b;
    logic         alu_enable;
    logic [N-1:0] alu_result;
    logic         alu_overflow, alu_zero, alu_negative;
    logic         flag_v, flag_z, flag_n;
    logic         wb_valid;
    logic [2:0]   wb_addr;
    logic [N-1:0] wb_data;
    logic [2:0]   dbg_addr;
    logic [N-1:0] dbg_data;

    int total = 0;
    int bad   = 0;

    alu_exec_ctrl #(.N(N)) dut (
        .clk(clk), .rst(rst),
        .instr_valid(instr_valid), .instr(instr), .instr_ready(instr_ready),
        .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data),
        .alu_control(alu_control), .alu_a(alu_a), .alu_b(alu_b),
        .alu_enable(alu_enable), .alu_result(alu_result),
        .alu_overflow(alu_overflow), .alu_zero(alu_zero), .alu_negative(alu_negative),
        .flag_v(flag_v), .flag_z(flag_z), .flag_n(flag_n),
        .wb_valid(wb_valid), .wb_addr(wb_addr), .wb_data(wb_data),
        .dbg_addr(dbg_addr), .dbg_data(dbg_data)
    );

    always #5 clk = ~clk;

    // Behavioural alu: evaluates on the rising edge of enable.
    // 000 add, 001 sub, 010 and, 011 or, 100 xor, 101..111 multiply.
    initial begin
        alu_result = '0; alu_overflow = 1'b0; alu_zero = 1'b1; alu_negative = 1'b0;
    end
    always @(posedge alu_enable) begin
        logic [N-1:0] r;
        logic         v;
        v = 1'b0;
        case (alu_control)
            3'b000: begin r = alu_a + alu_b; v = (alu_a[N-1] == alu_b[N-1]) && (r[N-1] != alu_a[N-1]); end
            3'b001: begin r = alu_a - alu_b; v = (alu_a[N-1] != alu_b[N-1]) && (r[N-1] != alu_a[N-1]); end
            3'b010: r = alu_a & alu_b;
            3'b011: r = alu_a | alu_b;
            3'b100: r = alu_a ^ alu_b;
            default: r = alu_a * alu_b;
        endcase
        alu_result   = r;
        alu_overflow = v;
        alu_zero     = (r == '0);
        alu_negative = r[N-1];
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic preload(input logic [2:0] a, input logic [N-1:0] d);
        ld_en = 1'b1; ld_addr = a; ld_data = d;
        tick();
        ld_en = 1'b0;
    endtask

    task automatic rd_dbg(input string tag, input logic [2:0] a, input logic [N-1:0] exp);
        dbg_addr = a;
        #1;
        chk(tag, dbg_data, exp);
    endtask

    // Issue one instruction from IDLE and follow it through E0..E3.
    task automatic run(input logic [2:0] op, input logic [2:0] rd, input logic [2:0] ra,
                       input logic [2:0] rb, input logic [N-1:0] ea, input logic [N-1:0] eb);
        instr_valid = 1'b1;
        instr = {op, rd, ra, rb, 4'h0};
        tick();                                     // E0
        instr_valid = 1'b0; ld_en = 1'b0;
        chk("ready_low_after_accept", instr_ready, 0);
        tick();                                     // E1
        chk("alu_a", alu_a, ea);
        chk("alu_b", alu_b, eb);
        chk("alu_control", alu_control, op);
        chk("enable_low_e1", alu_enable, 0);
        tick();                                     // E2
        chk("enable_high_e2", alu_enable, 1);
        chk("wb_valid_low_e2", wb_valid, 0);
        tick();                                     // E3
        chk("enable_low_e3", alu_enable, 0);
        chk("wb_valid_e3", wb_valid, 1);
        chk("wb_addr_e3", wb_addr, rd);
        chk("ready_e3", instr_ready, 1);
    endtask

    initial begin
        int acc_cyc [3];
        int accepts;
        logic took;

        rst = 1'b1; instr_valid = 1'b0; instr = '0;
        ld_en = 1'b0; ld_addr = '0; ld_data = '0; dbg_addr = '0;
        tick(); tick();
        rst = 1'b0;

        // Reset state
        chk("rst_ready", instr_ready, 1);
        chk("rst_enable", alu_enable, 0);
        chk("rst_alu_a", alu_a, 0);
        chk("rst_alu_b", alu_b, 0);
        chk("rst_control", alu_control, 0);
        chk("rst_flags", {flag_v, flag_z, flag_n}, 3'b000);
        chk("rst_wb_valid", wb_valid, 0);
        chk("rst_wb_addr", wb_addr, 0);
        chk("rst_wb_data", wb_data, 0);
        rd_dbg("rst_r1", 3'd1, 16'h0000);

        // add r3 = 5 + 3
        preload(3'd1, 16'h0005);
        preload(3'd2, 16'h0003);
        run(3'b000, 3'd3, 3'd1, 3'd2, 16'h0005, 16'h0003);
        chk("add_wb_data", wb_data, 16'h0008);
        chk("add_flags", {flag_v, flag_z, flag_n}, 3'b000);
        rd_dbg("add_r3", 3'd3, 16'h0008);
        tick();
        chk("wb_valid_one_cycle", wb_valid, 0);

        // add overflow r4 = 0x7FFF + 1
        preload(3'd1, 16'h7FFF);
        preload(3'd2, 16'h0001);
        run(3'b000, 3'd4, 3'd1, 3'd2, 16'h7FFF, 16'h0001);
        chk("ovf_wb_data", wb_data, 16'h8000);
        chk("ovf_flags", {flag_v, flag_z, flag_n}, 3'b101);
        rd_dbg("ovf_r4", 3'd4, 16'h8000);

        // sub r5 = r1 - r1
        run(3'b001, 3'd5, 3'd1, 3'd1, 16'h7FFF, 16'h7FFF);
        chk("sub_wb_data", wb_data, 16'h0000);
        chk("sub_flags", {flag_v, flag_z, flag_n}, 3'b010);
        rd_dbg("sub_r5", 3'd5, 16'h0000);

        // xor into r0; a preload to r0 is also dropped
        preload(3'd0, 16'h1234);
        preload(3'd6, 16'h00FF);
        preload(3'd7, 16'h00FF);
        run(3'b100, 3'd0, 3'd6, 3'd7, 16'h00FF, 16'h00FF);
        chk("xor_wb_data", wb_data, 16'h0000);
        chk("xor_flags", {flag_v, flag_z, flag_n}, 3'b010);
        rd_dbg("xor_r0", 3'd0, 16'h0000);

        // Multiply through op 111, with preload and accept in the same cycle
        ld_en = 1'b1; ld_addr = 3'd1; ld_data = 16'h0003;
        run(3'b111, 3'd2, 3'd1, 3'd6, 16'h0003, 16'h00FF);
        chk("mul_wb_data", wb_data, 16'h02FD);
        chk("mul_flags", {flag_v, flag_z, flag_n}, 3'b000);
        rd_dbg("mul_r2", 3'd2, 16'h02FD);

        // Back-to-back chain r1=r1+r1 three times from r1=1; noise during busy cycles
        preload(3'd1, 16'h0001);
        accepts = 0;
        instr_valid = 1'b1;
        instr = {3'b000, 3'd1, 3'd1, 3'd1, 4'h1};
        for (int cyc = 0; cyc < 20 && accepts < 3; cyc++) begin
            took = instr_ready;
            if (took) begin
                ld_en = 1'b0;
                acc_cyc[accepts] = cyc;
                accepts++;
            end else begin
                ld_en = 1'b1;
                ld_addr = (cyc % 2 == 0) ? 3'd1 : 3'd3;
                ld_data = 16'hDEAD;
            end
            tick();
            if (took) instr[3:0] = instr[3:0] + 4'h1;
        end
        chk("chain_accepts", accepts, 3);
        chk("chain_gap1", acc_cyc[1] - acc_cyc[0], 4);
        chk("chain_gap2", acc_cyc[2] - acc_cyc[1], 4);
        // Busy cycles of the last instruction: offer another instruction and preload
        instr = {3'b100, 3'd5, 3'd1, 3'd1, 4'h0};
        for (int cyc = 0; cyc < 3; cyc++) begin
            ld_en = 1'b1; ld_addr = 3'd1; ld_data = 16'hDEAD;
            tick();
        end
        instr_valid = 1'b0; ld_en = 1'b0;
        chk("chain_wb_valid", wb_valid, 1);
        chk("chain_wb_addr", wb_addr, 3'd1);
        chk("chain_wb_data", wb_data, 16'h0008);
        rd_dbg("chain_r1", 3'd1, 16'h0008);
        rd_dbg("chain_r3_untouched", 3'd3, 16'h0008);
        tick();
        chk("no_queued_instr", instr_ready, 1);
        chk("no_queued_wb", wb_valid, 0);

        // Reset during EXEC
        instr_valid = 1'b1;
        instr = {3'b000, 3'd3, 3'd1, 3'd1, 4'h0};
        tick();                                     // E0
        instr_valid = 1'b0;
        tick();                                     // E1, now in EXEC
        chk("pre_rst_enable", alu_enable, 0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("mid_rst_ready", instr_ready, 1);
        chk("mid_rst_enable", alu_enable, 0);
        chk("mid_rst_wb_valid", wb_valid, 0);
        chk("mid_rst_flags", {flag_v, flag_z, flag_n}, 3'b000);
        chk("mid_rst_alu_a", alu_a, 0);
        rd_dbg("mid_rst_r3", 3'd3, 16'h0000);
        rd_dbg("mid_rst_r1", 3'd1, 16'h0000);
        tick();
        chk("post_rst_wb_valid", wb_valid, 0);
        chk("post_rst_enable", alu_enable, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Watchdog so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
